// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and
// the sizing helper for the per-grant burst counter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_G0   = 2'd1,
        ARB_G1   = 2'd2
    } arb_state_t;

    // Counter must hold the value MAX_BURST itself, not just MAX_BURST-1.
    function automatic int burst_cnt_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between two producers,
// with a bounded burst per grant and backpressure from the FIFO full flag.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [width-1:0] data0,
    input  logic [width-1:0] data1,
    input  logic             full,
    output logic             grant0,
    output logic             grant1,
    output logic             write,
    output logic [width-1:0] inputBus
);

    localparam int               CNT_W       = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    arb_state_t       state;
    logic [CNT_W-1:0] burst_cnt;
    logic             last_served;

    logic             owner_req;
    logic             other_req;
    logic [CNT_W-1:0] cnt_inc;
    logic             grant_end;

    // Grants decode the state register directly, so they are registered
    // and drop together with the asynchronous reset.
    assign grant0 = (state == ARB_G0);
    assign grant1 = (state == ARB_G1);
    assign write  = (grant0 & req0 & ~full) | (grant1 & req1 & ~full);

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        owner_req = 1'b0;
        other_req = 1'b0;
        inputBus  = '0;
        case (state)
            ARB_G0: begin
                owner_req = req0;
                other_req = req1;
                inputBus  = data0;
            end
            ARB_G1: begin
                owner_req = req1;
                other_req = req0;
                inputBus  = data1;
            end
            default: ;
        endcase
    end

    // The word accepted this cycle counts toward the limit, so rotation
    // happens on the same edge that takes the last word of the burst.
    assign cnt_inc   = burst_cnt + CNT_W'(write);
    assign grant_end = ~owner_req | (cnt_inc == BURST_LIMIT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ARB_IDLE;
            burst_cnt   <= '0;
            last_served <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    burst_cnt <= '0;
                    if (req0 && req1) begin
                        state <= last_served ? ARB_G0 : ARB_G1;
                    end else if (req0) begin
                        state <= ARB_G0;
                    end else if (req1) begin
                        state <= ARB_G1;
                    end
                end
                ARB_G0, ARB_G1: begin
                    if (grant_end) begin
                        last_served <= (state == ARB_G1);
                        burst_cnt   <= '0;
                        if (other_req) begin
                            state <= (state == ARB_G0) ? ARB_G1 : ARB_G0;
                        end else if (!owner_req) begin
                            state <= ARB_IDLE;
                        end
                    end else begin
                        burst_cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= ARB_IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic on a
// MAX_BURST=4 and a MAX_BURST=1 instance checked against a transaction-level model.
module tb_fifo_write_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, req1, full;
    logic [W-1:0] data0, data1;

    logic         a_g0, a_g1, a_wr;
    logic [W-1:0] a_bus;
    logic         b_g0, b_g1, b_wr;
    logic [W-1:0] b_bus;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.width(W), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .full(full),
        .grant0(a_g0), .grant1(a_g1), .write(a_wr), .inputBus(a_bus)
    );

    fifo_write_arbiter #(.width(W), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .full(full),
        .grant0(b_g0), .grant1(b_g1), .write(b_wr), .inputBus(b_bus)
    );

    // Reference model: owner -1 = nobody, 0/1 = producer; cnt = words taken this grant.
    int m_owner[2];
    int m_cnt[2];
    int m_last[2];
    int m_max[2] = '{4, 1};

    task automatic model_step(input int k);
        bit r[2];
        int o, words;
        r[0] = req0;
        r[1] = req1;
        o = m_owner[k];
        if (o < 0) begin
            m_cnt[k] = 0;
            if (r[0] && r[1]) m_owner[k] = (m_last[k] == 0) ? 1 : 0;
            else if (r[0])    m_owner[k] = 0;
            else if (r[1])    m_owner[k] = 1;
        end else begin
            words = m_cnt[k] + ((r[o] && !full) ? 1 : 0);
            if (!r[o] || words >= m_max[k]) begin
                m_last[k] = o;
                m_cnt[k]  = 0;
                if (r[1-o])    m_owner[k] = 1 - o;
                else if (r[o]) m_owner[k] = o;
                else           m_owner[k] = -1;
            end else begin
                m_cnt[k] = words;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_owner[k] = -1;
                m_cnt[k]   = 0;
                m_last[k]  = 1;
            end
        end else begin
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    function automatic logic [W+2:0] model_out(input int k);
        logic         g0, g1, wr;
        logic [W-1:0] bus;
        g0  = (m_owner[k] == 0);
        g1  = (m_owner[k] == 1);
        wr  = (g0 && req0 && !full) || (g1 && req1 && !full);
        bus = g0 ? data0 : (g1 ? data1 : '0);
        return {g0, g1, wr, bus};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        full  = 1'b0;
        data0 = '0;
        data1 = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        full  = 1'b0;
        data0 = 8'hA0;
        data1 = 8'hB1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr, a_bus, b_g0, b_g1, b_wr, b_bus} !== '0) begin
                n_err++;
                $display("FAIL reset_values: a=%b%b%b/%h b=%b%b%b/%h, want all zero",
                         a_g0, a_g1, a_wr, a_bus, b_g0, b_g1, b_wr, b_bus);
            end
        end
        do_reset();
    endtask

    task automatic test_single_producer();
        do_reset();
        req0  = 1'b1;
        data0 = 8'h7E;
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr} !== 3'b000) begin
            n_err++;
            $display("FAIL single_latency: g0 g1 wr=%b%b%b, want 000", a_g0, a_g1, a_wr);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr, a_bus} !== {3'b101, 8'h7E}) begin
                n_err++;
                $display("FAIL single_write[%0d]: g0 g1 wr=%b%b%b bus=%h, want 101 7e",
                         i, a_g0, a_g1, a_wr, a_bus);
            end
            next_cycle();
        end
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr} !== 3'b100) begin
            n_err++;
            $display("FAIL single_drop: g0 g1 wr=%b%b%b, want 100", a_g0, a_g1, a_wr);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr, a_bus} !== '0) begin
            n_err++;
            $display("FAIL single_idle: g0 g1 wr=%b%b%b bus=%h, want 000 00",
                     a_g0, a_g1, a_wr, a_bus);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] exp_bus;
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'hA0;
        data1 = 8'hB1;
        next_cycle();
        for (int i = 0; i < 12; i++) begin
            exp_bus = ((i / 4) % 2 == 0) ? 8'hA0 : 8'hB1;
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr, a_bus} !== {exp_bus == 8'hA0, exp_bus == 8'hB1, 1'b1, exp_bus}) begin
                n_err++;
                $display("FAIL round_robin[%0d]: g0 g1 wr=%b%b%b bus=%h, want bus %h with write",
                         i, a_g0, a_g1, a_wr, a_bus, exp_bus);
            end
            next_cycle();
        end
    endtask

    task automatic test_full_hold();
        do_reset();
        req1  = 1'b1;
        data0 = 8'hA0;
        data1 = 8'hB1;
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr, a_bus} !== {3'b011, 8'hB1}) begin
            n_err++;
            $display("FAIL full_first_word: g0 g1 wr=%b%b%b bus=%h, want 011 b1",
                     a_g0, a_g1, a_wr, a_bus);
        end
        next_cycle();
        req0 = 1'b1;
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr} !== 3'b010) begin
                n_err++;
                $display("FAIL full_hold[%0d]: g0 g1 wr=%b%b%b, want 010", i, a_g0, a_g1, a_wr);
            end
            next_cycle();
        end
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr, a_bus} !== {3'b011, 8'hB1}) begin
                n_err++;
                $display("FAIL full_resume[%0d]: g0 g1 wr=%b%b%b bus=%h, want 011 b1",
                         i, a_g0, a_g1, a_wr, a_bus);
            end
            next_cycle();
        end
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr, a_bus} !== {3'b101, 8'hA0}) begin
            n_err++;
            $display("FAIL full_rotate: g0 g1 wr=%b%b%b bus=%h, want 101 a0",
                     a_g0, a_g1, a_wr, a_bus);
        end
    endtask

    task automatic test_drop_mid_burst();
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'hA0;
        data1 = 8'hB1;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr, a_bus} !== {3'b101, 8'hA0}) begin
                n_err++;
                $display("FAIL drop_words[%0d]: g0 g1 wr=%b%b%b bus=%h, want 101 a0",
                         i, a_g0, a_g1, a_wr, a_bus);
            end
            next_cycle();
        end
        req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr} !== 3'b100) begin
            n_err++;
            $display("FAIL drop_gap: g0 g1 wr=%b%b%b, want 100", a_g0, a_g1, a_wr);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if ({a_g0, a_g1, a_wr, a_bus} !== {3'b011, 8'hB1}) begin
            n_err++;
            $display("FAIL drop_rotate: g0 g1 wr=%b%b%b bus=%h, want 011 b1",
                     a_g0, a_g1, a_wr, a_bus);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [W-1:0] exp_bus;
        do_reset();
        req0  = 1'b1;
        data0 = 8'hA0;
        data1 = 8'hB1;
        for (int i = 0; i < 3; i++) next_cycle();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({a_g0, a_g1, a_wr, a_bus} !== '0) begin
            n_err++;
            $display("FAIL reset_async: g0 g1 wr=%b%b%b bus=%h, want 000 00",
                     a_g0, a_g1, a_wr, a_bus);
        end
        req1 = 1'b1;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            exp_bus = (i < 4) ? 8'hA0 : 8'hB1;
            @(negedge clk);
            n_cmp++;
            if ({a_g0, a_g1, a_wr, a_bus} !== {i < 4, i >= 4, 1'b1, exp_bus}) begin
                n_err++;
                $display("FAIL reset_regrant[%0d]: g0 g1 wr=%b%b%b bus=%h, want bus %h",
                         i, a_g0, a_g1, a_wr, a_bus, exp_bus);
            end
            next_cycle();
        end
    endtask

    task automatic test_max_burst_one();
        logic [W-1:0] exp_bus;
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'hA0;
        data1 = 8'hB1;
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            exp_bus = (i % 2 == 0) ? 8'hA0 : 8'hB1;
            @(negedge clk);
            n_cmp++;
            if ({b_g0, b_g1, b_wr, b_bus} !== {i % 2 == 0, i % 2 == 1, 1'b1, exp_bus}) begin
                n_err++;
                $display("FAIL burst_one[%0d]: g0 g1 wr=%b%b%b bus=%h, want bus %h",
                         i, b_g0, b_g1, b_wr, b_bus, exp_bus);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic [W+2:0] act, exp;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            req0  = ($urandom_range(0, 3) != 0);
            req1  = ($urandom_range(0, 3) != 0);
            full  = ($urandom_range(0, 4) == 0);
            data0 = W'($urandom);
            data1 = W'($urandom);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                act = (k == 0) ? {a_g0, a_g1, a_wr, a_bus} : {b_g0, b_g1, b_wr, b_bus};
                exp = model_out(k);
                n_cmp++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL random[%0d] dut%0d: g0 g1 wr bus=%b %h, want %b %h",
                             i, k, act[W+2:W], act[W-1:0], exp[W+2:W], exp[W-1:0]);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full_hold();
        test_drop_mid_burst();
        test_reset_mid_burst();
        test_max_burst_one();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
